sram_ctrl: RTL and testbench
============================

# sram_ctrl

Memory controller sitting directly downstream of the ACE `cpu` on the DE2 board. It turns the CPU's 32-bit word read/write request/acknowledge handshake into two sequential 16-bit accesses on the external asynchronous SRAM, low half first. It also exports its FSM state for the debug LEDs.

## Interface
- `WAIT_CYCLES`, default 1: cycles per SRAM access phase; minimum 1.
- `clk`  in  1  system clock (`better_clock` domain)
- `rst`  in  1  reset; asynchronous, active-high
- `mem_read`  in  1  read request; level, held until `mem_ack`
- `mem_write`  in  1  write request; level, held until `mem_ack`
- `mem_addr`  in  32  byte address; bits [20:2] used, the rest ignored
- `mem_write_data`  in  32  write word
- `mem_byte_en`  in  4  byte mask; present only with `SRAM_CTRL_BYTE_MASK_EN`
- `mem_read_data`  out  32  read word; valid while `mem_ack` is high
- `mem_ack`  out  1  one-cycle completion pulse
- `sram_addr`  out  20  half-word address
- `sram_dq`  inout  16  data bus
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM strobes
- `state`  out  3  current FSM encoding

## Operation
- **States and encodings:** IDLE=0, RD_LO=1, RD_HI=2, WR_LO=3, WR_HI=4, ACK=5.
- **Request acceptance (IDLE only):**
  - `mem_read` → RD_LO.
  - else `mem_write` → WR_LO.
  - Both asserted → read performed, write dropped.
  - At acceptance, `mem_addr[20:2]`, write data and mask are latched. Input changes after acceptance are ignored.
- **Address mapping:** low half-word at `{addr[20:2],1'b0}`, high half-word at `{addr[20:2],1'b1}`.
- **Read phase:** lasts `WAIT_CYCLES` cycles with `ce_n=0`, `oe_n=0`, `we_n=1`, `dq` high-Z.
  - On the last cycle, `dq` is captured: RD_LO into an internal low register, RD_HI into `mem_read_data`.
  - On the edge entering ACK, both halves are loaded into `mem_read_data` together.
- **Write phase:** lasts `WAIT_CYCLES+1` cycles with `ce_n=0`, `oe_n=1`, `dq` driven with the latched half.
  - `we_n=0` for the first `WAIT_CYCLES` cycles, then 1 for the final hold cycle.
  - The address never changes while `we_n=0`.
- **ACK:** `mem_ack=1` for exactly one cycle, then unconditionally → IDLE. Requests are not sampled in ACK.
- **Strobes:** `ce_n=1` in IDLE and ACK. `ub_n`/`lb_n` are 0 in every access state, unless masked.
- **Read data hold:** `mem_read_data` holds its value until the next read completes. Writes do not change it.
- **Reset (any time, including mid-access):**
  - state IDLE; `mem_ack=0`; `mem_read_data=0`; `sram_addr=0`.
  - all `_n` strobes high; `dq` high-Z.
  - An interrupted access is abandoned and no ack is issued.

## Timing
- The cycle after the accepting edge is cycle 1. W = `WAIT_CYCLES`.
- **Read:** RD_LO in cycles 1..W, RD_HI in W+1..2W, `mem_ack` in cycle 2W+1.
- **Write:** WR_LO in cycles 1..W+1, WR_HI in W+2..2W+2, `mem_ack` in cycle 2W+3.
- All outputs are registered or decoded from registered state. There is no combinational path from `mem_*` inputs to SRAM pins.
- **Back-to-back requests:** the CPU drops its request in the cycle after the ack. A request still high in IDLE is treated as new. Throughput with W=1 is one read every 4 cycles including IDLE.

## Configuration
- **`SRAM_CTRL_BYTE_MASK_EN` defined:**
  - The `mem_byte_en` port exists.
  - In WR_LO, `lb_n=!be[0]` and `ub_n=!be[1]`. In WR_HI, `lb_n=!be[2]` and `ub_n=!be[3]`.
  - A fully masked half still runs its phase with `ub_n=lb_n=1`.
  - Reads ignore the mask.
- **Not defined:** the port is absent and all writes are full 32-bit.

## Structure
- **Package `sram_ctrl_pkg`:** state enum with the encodings above, `SRAM_ADDR_W=20`, `SRAM_DATA_W=16`.
- **Sub-module `sram_phase_timer`:** down-counter loaded with W or W+1 at each phase entry. It asserts `last` on the final phase cycle and `we_win` while the count is above the final cycle.

## Test plan
- **Write, W=1:** write 0xDEADBEEF at `mem_addr` 0x00000010 → SRAM[0x00008]=0xBEEF, SRAM[0x00009]=0xDEAD; `we_n` low in cycles 1 and 3 only; `mem_ack` in cycle 5.
- **Read back, W=1:** read 0x00000010 → `mem_read_data`=0xDEADBEEF with `mem_ack` in cycle 3; `oe_n` low in cycles 1–2; `state` sequence 1,2,5,0.
- **Simultaneous read and write:** both asserted at 0x10 with write data 0x12345678 → read returns 0xDEADBEEF and SRAM is unchanged.
- **`WAIT_CYCLES=3`, read:** `oe_n` low in cycles 1–6, `mem_ack` in cycle 7. **Write:** `mem_ack` in cycle 9; `we_n` high in cycles 4 and 8.
- **Reset mid-access:** assert `rst` in cycle 3 of a write → `we_n`, `ce_n`, `oe_n` go high and `dq` goes high-Z immediately; `state`=0; no `mem_ack`; a subsequent read returns defined data.
- **Byte mask (macro on):** mask 4'b0010, write 0xAABBCCDD over 0 → low half-word becomes 0xCC00, high half-word stays 0x0000; `ub_n=lb_n=1` throughout WR_HI.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the sram_ctrl 32-bit-to-16-bit SRAM bridge.
package sram_ctrl_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    ACK   = 3'd5
  } state_t;
endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase down-counter: loaded with W (read) or W+1 (write) on phase entry.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic is_write,
  output logic last,
  output logic we_win
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= is_write ? CNT_W'(WAIT_CYCLES + 1) : CNT_W'(WAIT_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Count of 1 marks the final cycle; in a write phase that is the hold cycle.
  assign last   = (count == CNT_W'(1));
  assign we_win = (count > CNT_W'(1));
endmodule

// File: rtl/sram_ctrl.sv
// CPU word handshake to two 16-bit async SRAM accesses, low half first.
// Optional byte-lane masking on writes when SRAM_CTRL_BYTE_MASK_EN is defined.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_write_data,
`ifdef SRAM_CTRL_BYTE_MASK_EN
  input  logic [3:0]             mem_byte_en,
`endif
  output logic [31:0]            mem_read_data,
  output logic                   mem_ack,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic [2:0]             state
);
  state_t                 state_reg;
  logic [18:0]            addr_reg;
  logic [31:0]            wdata_reg;
  logic [3:0]             be_reg;
  logic [3:0]             be_in;
  logic [SRAM_DATA_W-1:0] lo_reg;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic                   dq_drive;
  logic                   half_sel;
  logic                   phase_load;
  logic                   phase_is_write;
  logic                   last;
  logic                   we_win;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr[31:21], mem_addr[1:0]};

`ifdef SRAM_CTRL_BYTE_MASK_EN
  assign be_in = mem_byte_en;
`else
  assign be_in = 4'hF;
`endif

  assign phase_load = ((state_reg == IDLE) && (mem_read || mem_write)) ||
                      ((state_reg == RD_LO) && last) ||
                      ((state_reg == WR_LO) && last);
  // A simultaneous read and write is taken as a read, so only a lone write loads W+1.
  assign phase_is_write = (state_reg == IDLE) ? !mem_read : (state_reg == WR_LO);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .is_write (phase_is_write),
    .last     (last),
    .we_win   (we_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= 4'hF;
      lo_reg        <= '0;
      mem_read_data <= '0;
      mem_ack       <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_reg  <= mem_addr[20:2];
            wdata_reg <= mem_write_data;
            be_reg    <= be_in;
            state_reg <= mem_read ? RD_LO : WR_LO;
          end
        end
        RD_LO: if (last) begin
          lo_reg    <= sram_dq;
          state_reg <= RD_HI;
        end
        RD_HI: if (last) begin
          mem_read_data <= {sram_dq, lo_reg};
          mem_ack       <= 1'b1;
          state_reg     <= ACK;
        end
        WR_LO: if (last) state_reg <= WR_HI;
        WR_HI: if (last) begin
          mem_ack   <= 1'b1;
          state_reg <= ACK;
        end
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_lb_n = 1'b1;
    sram_ub_n = 1'b1;
    half_sel  = 1'b0;
    dq_drive  = 1'b0;
    dq_out    = wdata_reg[15:0];
    case (state_reg)
      RD_LO, RD_HI: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_ub_n = 1'b0;
        half_sel  = (state_reg == RD_HI);
      end
      WR_LO: begin
        sram_ce_n = 1'b0;
        sram_we_n = !we_win;
        sram_lb_n = !be_reg[0];
        sram_ub_n = !be_reg[1];
        dq_drive  = 1'b1;
      end
      WR_HI: begin
        sram_ce_n = 1'b0;
        sram_we_n = !we_win;
        sram_lb_n = !be_reg[2];
        sram_ub_n = !be_reg[3];
        dq_drive  = 1'b1;
        dq_out    = wdata_reg[31:16];
        half_sel  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_addr = {addr_reg, half_sel};
  assign sram_dq   = dq_drive ? dq_out : 'z;
  assign state     = state_reg;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with WAIT_CYCLES=1 and one with 3, each on its own SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b0;
  always #5 clk = ~clk;

  logic        mem_read [2];
  logic        mem_write[2];
  logic [31:0] mem_addr [2];
  logic [31:0] wdata    [2];
  logic [3:0]  be       [2];
  logic [31:0] rdata    [2];
  logic        ack      [2];
  logic [19:0] saddr    [2];
  logic        we_n[2], oe_n[2], ce_n[2], ub_n[2], lb_n[2];
  logic [2:0]  st       [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [2][2048];
  logic [31:0] last_rd [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int WC = (gi == 0) ? 1 : 3;
    wire  [15:0] dq_w;
    logic [15:0] sram_mem [0:4095];

    sram_ctrl #(.WAIT_CYCLES(WC)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read       (mem_read[gi]),
      .mem_write      (mem_write[gi]),
      .mem_addr       (mem_addr[gi]),
      .mem_write_data (wdata[gi]),
`ifdef SRAM_CTRL_BYTE_MASK_EN
      .mem_byte_en    (be[gi]),
`endif
      .mem_read_data  (rdata[gi]),
      .mem_ack        (ack[gi]),
      .sram_addr      (saddr[gi]),
      .sram_dq        (dq_w),
      .sram_we_n      (we_n[gi]),
      .sram_oe_n      (oe_n[gi]),
      .sram_ce_n      (ce_n[gi]),
      .sram_ub_n      (ub_n[gi]),
      .sram_lb_n      (lb_n[gi]),
      .state          (st[gi])
    );

    // Async SRAM: drives the bus when selected for read, commits lanes at the end of a we_n-low cycle.
    assign dq_w = (!ce_n[gi] && !oe_n[gi] && we_n[gi]) ? sram_mem[saddr[gi][11:0]] : 16'hzzzz;

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 4096; i++) sram_mem[i] <= 16'h0000;
      end else if (!ce_n[gi] && !we_n[gi]) begin
        if (!lb_n[gi]) sram_mem[saddr[gi][11:0]][7:0]  <= dq_w[7:0];
        if (!ub_n[gi]) sram_mem[saddr[gi][11:0]][15:8] <= dq_w[15:8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Expected state in cycle c after acceptance, straight from the timing rules.
  function automatic logic [2:0] exp_state(input int w, input bit rd, input int c);
    if (rd) begin
      if (c <= w)          return 3'd1;
      if (c <= 2 * w)      return 3'd2;
      if (c == 2 * w + 1)  return 3'd5;
    end else begin
      if (c <= w + 1)      return 3'd3;
      if (c <= 2 * w + 2)  return 3'd4;
      if (c == 2 * w + 3)  return 3'd5;
    end
    return 3'd0;
  endfunction

  function automatic logic [31:0] cyc_mask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int c = lo; c <= hi; c++) m[c] = 1'b1;
    return m;
  endfunction

  task automatic run_op(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] bmask,
                        output logic [31:0] got_rd, output int ack_c, output logic [31:0] oe_m,
                        output logic [31:0] we_m, output logic [31:0] hi_m, output int st_err,
                        output logic [19:0] a1);
    int w = wc(k);
    got_rd = '0; ack_c = -1; oe_m = '0; we_m = '0; hi_m = '0; st_err = 0; a1 = '0;
    @(negedge clk);
    mem_read[k] = rd; mem_write[k] = wr; mem_addr[k] = addr; wdata[k] = data; be[k] = bmask;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a1 = saddr[k];
        mem_addr[k] = ~addr; wdata[k] = ~data; be[k] = ~bmask;
      end
      if (!oe_n[k]) oe_m[c] = 1'b1;
      if (!we_n[k]) we_m[c] = 1'b1;
      if (!ce_n[k] && ub_n[k] && lb_n[k]) hi_m[c] = 1'b1;
      if (st[k] !== exp_state(w, rd, c)) st_err++;
      if (ack[k]) begin
        ack_c = c;
        got_rd = rdata[k];
        mem_read[k] = 1'b0; mem_write[k] = 1'b0;
        break;
      end
    end
    @(negedge clk);
    if (ack[k] !== 1'b0 || st[k] !== 3'd0) st_err++;
  endtask

  task automatic xact(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] bmask,
                      input logic [31:0] exp_rd, input int exp_ack);
    logic [31:0] got, oe_m, we_m, hi_m, exp_hi;
    int ack_c, st_err, w;
    logic [19:0] a1;
    w = wc(k);
    run_op(k, rd, wr, addr, data, bmask, got, ack_c, oe_m, we_m, hi_m, st_err, a1);
    $display("xact k=%0d W=%0d rd=%0d wr=%0d addr=%08h data=%08h rdata=%08h ack_cycle=%0d",
             k, w, rd, wr, addr, data, got, ack_c);
    exp_hi = '0;
    if (!rd) begin
      if (bmask[1:0] == 2'b00) exp_hi |= cyc_mask(1, w + 1);
      if (bmask[3:2] == 2'b00) exp_hi |= cyc_mask(w + 2, 2 * w + 2);
    end
    check("ack_cycle", 32'(ack_c), 32'(exp_ack));
    check("read_data", got, exp_rd);
    check("oe_low_cycles", oe_m, rd ? cyc_mask(1, 2 * w) : 32'h0);
    check("we_low_cycles", we_m, rd ? 32'h0 : (cyc_mask(1, w) | cyc_mask(w + 2, 2 * w + 1)));
    check("lanes_off_cycles", hi_m, exp_hi);
    check("state_seq_errors", 32'(st_err), 32'h0);
    check("sram_addr_lo", 32'(a1), 32'({addr[20:2], 1'b0}));
    if (rd) begin
      last_rd[k] = exp_rd;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bmask[b]) ref_mem[k][addr[12:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  typedef struct {
    int          k;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_ack;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    vecs[0] = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 5};
    vecs[1] = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 3};
    vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 3};
    vecs[3] = '{0, 1'b1, 1'b0, 32'hFFE0_0012, 32'h0000_0000, 32'hDEAD_BEEF, 3};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 5};
    vecs[5] = '{0, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0000_0000, 32'hCAFE_F00D, 3};
    vecs[6] = '{1, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 32'h0000_0000, 9};
    vecs[7] = '{1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0BAD_C0DE, 7};
    vecs[8] = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 7};

    for (int k = 0; k < 2; k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; mem_addr[k] = '0; wdata[k] = '0; be[k] = 4'hF;
      last_rd[k] = '0;
      for (int i = 0; i < 2048; i++) ref_mem[k][i] = '0;
    end
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_state", 32'(st[k]), 32'h0);
      check("rst_ack", 32'(ack[k]), 32'h0);
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_sram_addr", 32'(saddr[k]), 32'h0);
      check("rst_strobes", 32'({we_n[k], oe_n[k], ce_n[k], ub_n[k], lb_n[k]}), 32'h1F);
    end
    mem_clr = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      xact(vecs[i].k, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 4'hF,
           vecs[i].exp_rd, vecs[i].exp_ack);

    check("sram0_8",     32'(g_inst[0].sram_mem[8]),      32'h0000_BEEF);
    check("sram0_9",     32'(g_inst[0].sram_mem[9]),      32'h0000_DEAD);
    check("sram0_ffe",   32'(g_inst[0].sram_mem[12'hFFE]), 32'h0000_F00D);
    check("sram0_fff",   32'(g_inst[0].sram_mem[12'hFFF]), 32'h0000_CAFE);
    check("sram1_16",    32'(g_inst[1].sram_mem[16]),     32'h0000_C0DE);
    check("sram1_17",    32'(g_inst[1].sram_mem[17]),     32'h0000_0BAD);

    // Reset in cycle 3 of a W=1 write: low half already committed, high half not.
    @(negedge clk);
    mem_write[0] = 1'b1; mem_addr[0] = 32'h0000_0100; wdata[0] = 32'h1111_2222; be[0] = 4'hF;
    repeat (3) @(negedge clk);
    check("mid_state_before_rst", 32'(st[0]), 32'h4);
    check("mid_we_before_rst", 32'(we_n[0]), 32'h0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_strobes", 32'({we_n[0], oe_n[0], ce_n[0], ub_n[0], lb_n[0]}), 32'h1F);
    check("mid_rst_state", 32'(st[0]), 32'h0);
    check("mid_rst_ack", 32'(ack[0]), 32'h0);
    check("mid_rst_rdata", rdata[0], 32'h0);
    check("mid_rst_sram_addr", 32'(saddr[0]), 32'h0);
    mem_write[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    ref_mem[0][11'h040] = 32'h0000_2222;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[0] || ack[1]) acks++;
    end
    check("no_ack_after_rst", 32'(acks), 32'h0);
    xact(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h0000_2222, 3);

`ifdef SRAM_CTRL_BYTE_MASK_EN
    xact(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, last_rd[0], 5);
    xact(0, 1'b0, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0010, last_rd[0], 5);
    check("mask_lo_half", 32'(g_inst[0].sram_mem[12'h020]), 32'h0000_CC00);
    check("mask_hi_half", 32'(g_inst[0].sram_mem[12'h021]), 32'h0000_0000);
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h0000_CC00, 3);
`endif

    for (int i = 0; i < 24; i++) begin
      int          k  = int'($urandom_range(0, 1));
      int          op = int'($urandom_range(0, 2));
      bit          rd = (op != 1);
      bit          wr = (op != 0);
      logic [31:0] addr = ($urandom & 32'hFFE0_0000) | (32'($urandom_range(0, 2047)) << 2) |
                          32'($urandom_range(0, 3));
      logic [31:0] data = $urandom;
      int          w  = wc(k);
      xact(k, rd, wr, addr, data, 4'hF, rd ? ref_mem[k][addr[12:2]] : last_rd[k],
           rd ? 2 * w + 1 : 2 * w + 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
